// File: rtl/muller_seq_pkg.sv
// Shared types and constants for the Muller C-gate self-test sequencer.
package muller_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_APPLY,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } seq_state_t;

  localparam int FIXED_LEN = 8;
  localparam int ERR_W     = 16;

  // Each entry is {a, b}; walks every C-gate transition including both hold cases.
  localparam logic [1:0] FIXED_ROM [FIXED_LEN] = '{
    2'b01, 2'b11, 2'b10, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00
  };

  // Right-shifting Fibonacci form of taps 16,14,13,11 (bits 0,2,3,5).
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/muller_seq_lfsr.sv
// 16-bit Fibonacci LFSR with seed reload and step enable; exposes only the low OUT_W bits.
module muller_seq_lfsr
  import muller_seq_pkg::*;
#(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  output logic [OUT_W-1:0] bits
);

  logic [15:0] state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     state <= SEED;
    else if (load)  state <= SEED;
    else if (step)  state <= {^(state & LFSR_TAPS), state[15:1]};
  end

  assign bits = state[OUT_W-1:0];

endmodule

// File: rtl/muller_c_sequencer.sv
// Self-test sequencer driving N_GATES Muller C gates and checking them against a reference model.
// Optional first-failure capture ports are enabled with `define MULLER_SEQ_FAIL_CAPTURE_EN.
module muller_c_sequencer
  import muller_seq_pkg::*;
#(
  parameter int          N_GATES       = 4,
  parameter int          SETTLE_CYCLES = 16,
  parameter int          NUM_VECTORS   = 256,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic               CLK_33MHZ_FPGA,
  input  logic               RST_N,
  input  logic               start,
  input  logic               mode,
  input  logic               stop_on_error,
  input  logic [N_GATES-1:0] gate_c,
  output logic [N_GATES-1:0] gate_a,
  output logic [N_GATES-1:0] gate_b,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [N_GATES-1:0] err_mask,
  output logic [ERR_W-1:0]   err_count,
  output logic [15:0]        vec_idx
`ifdef MULLER_SEQ_FAIL_CAPTURE_EN
  ,
  output logic [15:0]        first_fail_idx,
  output logic [N_GATES-1:0] first_fail_a,
  output logic [N_GATES-1:0] first_fail_b,
  output logic [N_GATES-1:0] first_fail_c
`endif
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES);

  seq_state_t           state;
  logic [CNT_W-1:0]     cnt;
  logic                 mode_q, stop_q;
  logic [N_GATES-1:0]   c_exp, sync1, sync2, mism, vec_a, vec_b;
  logic [2*N_GATES-1:0] lfsr_bits;
  logic [15:0]          last_idx;
  logic                 accept, cnt_last, at_last, stop_now, lfsr_step;
  logic [ERR_W:0]       pop_ext, err_sum;

  muller_seq_lfsr #(.SEED(LFSR_SEED), .OUT_W(2*N_GATES)) u_lfsr (
    .clk   (CLK_33MHZ_FPGA),
    .rst_n (RST_N),
    .load  (accept),
    .step  (lfsr_step),
    .bits  (lfsr_bits)
  );

  always_ff @(posedge CLK_33MHZ_FPGA or negedge RST_N) begin
    if (!RST_N) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= gate_c;
      sync2 <= sync1;
    end
  end

  assign mism      = sync2 ^ c_exp;
  assign accept    = start && !busy && (state == ST_IDLE || state == ST_DONE);
  assign cnt_last  = (cnt == CNT_W'(SETTLE_CYCLES - 1));
  assign last_idx  = mode_q ? 16'(NUM_VECTORS - 1) : 16'(FIXED_LEN - 1);
  assign at_last   = (vec_idx == last_idx);
  assign stop_now  = stop_q && (mism != '0);
  assign lfsr_step = (state == ST_CHECK) && !stop_now && !at_last;
  assign pop_ext   = {{(ERR_W - 3){1'b0}}, popcount8(8'(mism))};
  assign err_sum   = {1'b0, err_count} + pop_ext;

  always_comb begin
    vec_a = '0;
    vec_b = '0;
    if (mode_q) begin
      for (int i = 0; i < N_GATES; i++) begin
        vec_a[i] = lfsr_bits[2*i];
        vec_b[i] = lfsr_bits[2*i+1];
      end
    end else begin
      vec_a = {N_GATES{FIXED_ROM[vec_idx[2:0]][1]}};
      vec_b = {N_GATES{FIXED_ROM[vec_idx[2:0]][0]}};
    end
  end

  // DONE spends its first cycle publishing the result; busy stays high until then.
  always_ff @(posedge CLK_33MHZ_FPGA or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      mode_q    <= 1'b0;
      stop_q    <= 1'b0;
      gate_a    <= '0;
      gate_b    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_mask  <= '0;
      err_count <= '0;
      vec_idx   <= '0;
      c_exp     <= '0;
    end else if (accept) begin
      mode_q    <= mode;
      stop_q    <= stop_on_error;
      err_mask  <= '0;
      err_count <= '0;
      vec_idx   <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      busy      <= 1'b1;
      cnt       <= '0;
      state     <= ST_INIT;
    end else begin
      case (state)
        ST_INIT: begin
          gate_a <= '0;
          gate_b <= '0;
          c_exp  <= '0;
          if (cnt_last) begin
            cnt   <= '0;
            state <= ST_APPLY;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_APPLY: begin
          gate_a <= vec_a;
          gate_b <= vec_b;
          c_exp  <= (vec_a & vec_b) | (c_exp & (vec_a | vec_b));
          cnt    <= '0;
          state  <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt_last) begin
            cnt   <= '0;
            state <= ST_CHECK;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_CHECK: begin
          err_mask  <= err_mask | mism;
          err_count <= err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
          if (stop_now || at_last) begin
            state <= ST_DONE;
          end else begin
            vec_idx <= vec_idx + 16'd1;
            state   <= ST_APPLY;
          end
        end
        ST_DONE: begin
          if (!done) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (err_count == '0);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MULLER_SEQ_FAIL_CAPTURE_EN
  always_ff @(posedge CLK_33MHZ_FPGA or negedge RST_N) begin
    if (!RST_N) begin
      first_fail_idx <= '0;
      first_fail_a   <= '0;
      first_fail_b   <= '0;
      first_fail_c   <= '0;
    end else if (accept) begin
      first_fail_idx <= '0;
      first_fail_a   <= '0;
      first_fail_b   <= '0;
      first_fail_c   <= '0;
    end else if (state == ST_CHECK && mism != '0 && err_count == '0) begin
      first_fail_idx <= vec_idx;
      first_fail_a   <= gate_a;
      first_fail_b   <= gate_b;
      first_fail_c   <= sync2;
    end
  end
`endif

endmodule
